hgcal_latent_deframer: RTL and testbench

- Receive-side counterpart of the encoder LUT network's latent output. The encoder emits N_LATENT quantised latent codes of BW bits each, framed and serialised onto a narrow word link.
- This block sits at the decoder end of that link. It checks each frame, unpacks the payload into a parallel latent vector, and presents the vector to the first decoder LUT layer over a valid/ready handshake.

---
 rtl/hgcal_link_pkg.sv | 19 +
 rtl/sat_counter.sv | 23 ++
 rtl/hgcal_latent_deframer.sv | 140 ++++++++++++++
 tb/tb_hgcal_latent_deframer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hgcal_link_pkg.sv
// Shared link definitions for the latent framer/deframer pair:
// FSM state encoding, default header word and payload-word derivation.
package hgcal_link_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2,
      HOLD    = 2'd3
   } link_state_e;

   localparam logic [7:0] HDR_DEFAULT = 8'hA5;

   // Number of link words carrying one frame's latent payload.
   function automatic int calc_nw(input int n_latent, input int bw, input int word_w);
      return (n_latent * bw) / word_w;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts up on inc and holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hgcal_latent_deframer.sv
// Link-side receiver for the encoder latent stream: hunts for the header,
// collects and XOR-checks the payload, and hands the latent vector to the decoder.
module hgcal_latent_deframer
   import hgcal_link_pkg::*;
#(
   parameter int                N_LATENT = 16,
   parameter int                BW       = 2,
   parameter int                WORD_W   = 8,
   parameter logic [WORD_W-1:0] HDR      = WORD_W'(HDR_DEFAULT),
   parameter int                CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WORD_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [N_LATENT*BW-1:0]   out_latent,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     err_pulse,
   output logic [CNT_W-1:0]         frame_cnt,
   output logic [CNT_W-1:0]         err_cnt
);

   localparam int VW = N_LATENT * BW;
   localparam int NW = calc_nw(N_LATENT, BW, WORD_W);
   localparam int CW = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);

   if ((VW % WORD_W) != 0) begin : g_width_check
      $error("N_LATENT*BW must be a multiple of WORD_W");
   end

   link_state_e       state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic [CW-1:0]     word_cnt_q;
   logic [WORD_W-1:0] xor_q;
   logic [WORD_W-1:0] shadow_q [NW];
   logic [VW-1:0]     shadow_flat;
   logic [NW-1:0]     slot_we;
   logic [VW-1:0]     out_latent_q;
   logic              out_valid_q;
   logic              err_pulse_q;

   logic xfer, hdr_seen, pay_xfer, check_ok, check_bad;

   assign xfer      = in_valid && in_ready_q;
   assign hdr_seen  = (state_q == HUNT) && xfer && (in_data == HDR);
   assign pay_xfer  = (state_q == PAYLOAD) && xfer;
   assign check_ok  = (state_q == CHECK) && xfer && (in_data == xor_q);
   assign check_bad = (state_q == CHECK) && xfer && (in_data != xor_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         HUNT:    if (hdr_seen) state_d = PAYLOAD;
         PAYLOAD: if (pay_xfer && (word_cnt_q == LAST_WORD)) state_d = CHECK;
         CHECK:   if (check_ok) state_d = HOLD;
                  else if (check_bad) state_d = HUNT;
         HOLD:    if (out_valid_q && out_ready) state_d = HUNT;
         default: state_d = HUNT;
      endcase
   end

   // in_ready is registered from the next state, so out_ready never reaches it combinationally.
   always_comb begin
      in_ready_d = 1'b1;
      if (state_d == HOLD) in_ready_d = 1'b0;
   end

   for (genvar gi = 0; gi < NW; gi++) begin : g_slot
      assign slot_we[gi] = pay_xfer && (word_cnt_q == CW'(gi));
      assign shadow_flat[gi*WORD_W +: WORD_W] = shadow_q[gi];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NW; i++) shadow_q[i] <= '0;
      end else begin
         for (int i = 0; i < NW; i++) begin
            if (slot_we[i]) shadow_q[i] <= in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_q   <= '0;
         xor_q        <= '0;
         out_latent_q <= '0;
         out_valid_q  <= 1'b0;
         err_pulse_q  <= 1'b0;
      end else begin
         err_pulse_q <= check_bad;
         if (hdr_seen) begin
            word_cnt_q <= '0;
            xor_q      <= '0;
         end else if (pay_xfer) begin
            word_cnt_q <= word_cnt_q + CW'(1);
            xor_q      <= xor_q ^ in_data;
         end
         if (check_ok) begin
            out_latent_q <= shadow_flat;
            out_valid_q  <= 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_q  <= 1'b0;
         end
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (check_ok),
      .cnt   (frame_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (check_bad),
      .cnt   (err_cnt)
   );

   assign in_ready   = in_ready_q;
   assign out_latent = out_latent_q;
   assign out_valid  = out_valid_q;
   assign err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_hgcal_latent_deframer.sv
// Self-checking bench for hgcal_latent_deframer: directed scenarios plus
// randomized frames compared against a frame-level reference model.
module tb_hgcal_latent_deframer;

   localparam int CNT_W = 4;
   localparam int CMAX  = 15;
   localparam logic [7:0] HDR = 8'hA5;

   logic        clk, rst_n;
   logic [7:0]  in_data;
   logic        in_valid, in_ready;
   logic [31:0] out_latent;
   logic        out_valid, out_ready, err_pulse;
   logic [3:0]  frame_cnt, err_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_frames = 0;
   int exp_errs = 0;
   int ep_cnt = 0;
   logic [31:0] got_q[$];

   hgcal_latent_deframer #(
      .N_LATENT (16),
      .BW       (2),
      .WORD_W   (8),
      .HDR      (8'hA5),
      .CNT_W    (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_latent (out_latent),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err_pulse  (err_pulse),
      .frame_cnt  (frame_cnt),
      .err_cnt    (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Observe handshakes and error pulses at the active edge.
   always @(posedge clk) begin
      if (out_valid && out_ready) got_q.push_back(out_latent);
      if (err_pulse) ep_cnt++;
   end

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   function automatic logic [7:0] frame_xor(input logic [31:0] lat);
      return lat[7:0] ^ lat[15:8] ^ lat[23:16] ^ lat[31:24];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] w);
      int t;
      t = 0;
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         tick();
         t++;
      end
      n_cmp++;
      if (!in_ready) begin
         $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
         n_bad++;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] lat, input bit corrupt, input bit gaps);
      logic [7:0] words [6];
      words[0] = HDR;
      for (int i = 0; i < 4; i++) words[i+1] = lat[i*8 +: 8];
      words[5] = frame_xor(lat) ^ (corrupt ? 8'h01 : 8'h00);
      for (int i = 0; i < 6; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(1, 3)) tick();
         end
         send_word(words[i]);
      end
      if (corrupt) exp_errs = sat_inc(exp_errs);
      else exp_frames = sat_inc(exp_frames);
   endtask

   task automatic wait_deliver(input bit rnd_ready, output logic [31:0] v, output bit ok);
      int t;
      t = 0;
      while (got_q.size() == 0 && t < 300) begin
         if (rnd_ready) out_ready = 1'($urandom);
         tick();
         t++;
      end
      ok = (got_q.size() != 0);
      v  = ok ? got_q.pop_front() : 32'h0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      repeat (3) tick();
      n_cmp += 6;
      if (in_ready !== 1'b0)   begin $display("FAIL reset_in_ready got=%0b exp=0", in_ready); n_bad++; end
      if (out_valid !== 1'b0)  begin $display("FAIL reset_out_valid got=%0b exp=0", out_valid); n_bad++; end
      if (out_latent !== 32'h0) begin $display("FAIL reset_out_latent got=%h exp=0", out_latent); n_bad++; end
      if (err_pulse !== 1'b0)  begin $display("FAIL reset_err_pulse got=%0b exp=0", err_pulse); n_bad++; end
      if (frame_cnt !== 4'h0)  begin $display("FAIL reset_frame_cnt got=%h exp=0", frame_cnt); n_bad++; end
      if (err_cnt !== 4'h0)    begin $display("FAIL reset_err_cnt got=%h exp=0", err_cnt); n_bad++; end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (in_ready !== 1'b1) begin $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); n_bad++; end
      exp_frames = 0; exp_errs = 0;
      $display("test_reset done");
   endtask

   task automatic test_good_frame();
      logic [31:0] lat, v;
      bit ok;
      lat = 32'hFF00E41B;
      out_ready = 1'b1;
      send_word(HDR);
      for (int i = 0; i < 4; i++) send_word(lat[i*8 +: 8]);
      n_cmp++;
      if (out_valid !== 1'b0) begin $display("FAIL good_early_valid got=%0b exp=0", out_valid); n_bad++; end
      send_word(frame_xor(lat));
      exp_frames = sat_inc(exp_frames);
      n_cmp += 5;
      if (out_valid !== 1'b1) begin $display("FAIL good_latency out_valid=%0b exp=1", out_valid); n_bad++; end
      if (out_latent !== 32'hFF00E41B) begin $display("FAIL good_latent got=%h exp=ff00e41b", out_latent); n_bad++; end
      if (out_latent[1:0] !== 2'b11) begin $display("FAIL good_latent0 got=%b exp=11", out_latent[1:0]); n_bad++; end
      if (out_latent[9:8] !== 2'b00) begin $display("FAIL good_latent4 got=%b exp=00", out_latent[9:8]); n_bad++; end
      if (frame_cnt !== 4'(exp_frames)) begin $display("FAIL good_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); n_bad++; end
      wait_deliver(1'b0, v, ok);
      n_cmp++;
      if (!ok || v !== lat) begin $display("FAIL good_deliver got=%h ok=%0b exp=%h", v, ok, lat); n_bad++; end
      $display("test_good_frame latent=%h", lat);
   endtask

   task automatic test_bad_checksum();
      logic [31:0] lat, v;
      bit ok;
      send_word(HDR);
      send_word(8'h1B); send_word(8'hE4); send_word(8'h00); send_word(8'hFF);
      send_word(8'h05);
      exp_errs = sat_inc(exp_errs);
      n_cmp += 2;
      if (err_pulse !== 1'b1) begin $display("FAIL bad_err_pulse got=%0b exp=1", err_pulse); n_bad++; end
      if (out_valid !== 1'b0) begin $display("FAIL bad_out_valid got=%0b exp=0", out_valid); n_bad++; end
      tick();
      n_cmp += 2;
      if (err_pulse !== 1'b0) begin $display("FAIL bad_pulse_width got=%0b exp=0", err_pulse); n_bad++; end
      if (err_cnt !== 4'(exp_errs)) begin $display("FAIL bad_err_cnt got=%0d exp=%0d", err_cnt, exp_errs); n_bad++; end
      lat = $urandom;
      send_frame(lat, 1'b0, 1'b0);
      wait_deliver(1'b0, v, ok);
      n_cmp++;
      if (!ok || v !== lat) begin $display("FAIL bad_then_good got=%h ok=%0b exp=%h", v, ok, lat); n_bad++; end
      $display("test_bad_checksum followup latent=%h", lat);
   endtask

   task automatic test_garbage();
      logic [31:0] lat, v;
      bit ok;
      send_word(8'h3C);
      send_word(8'h00);
      lat = $urandom;
      send_frame(lat, 1'b0, 1'b0);
      wait_deliver(1'b0, v, ok);
      repeat (3) tick();
      n_cmp += 3;
      if (!ok || v !== lat) begin $display("FAIL garbage_deliver got=%h ok=%0b exp=%h", v, ok, lat); n_bad++; end
      if (err_cnt !== 4'(exp_errs)) begin $display("FAIL garbage_err_cnt got=%0d exp=%0d", err_cnt, exp_errs); n_bad++; end
      if (got_q.size() != 0) begin $display("FAIL garbage_extra_frames got=%0d exp=0", got_q.size()); n_bad++; end
      $display("test_garbage latent=%h", lat);
   endtask

   task automatic test_back_to_back();
      logic [31:0] l1, l2, v;
      bit ok;
      int bad_rdy, bad_lat;
      l1 = $urandom; l2 = $urandom;
      out_ready = 1'b0;
      send_frame(l1, 1'b0, 1'b0);
      in_data = HDR; in_valid = 1'b1;
      bad_rdy = 0; bad_lat = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (in_ready !== 1'b0) bad_rdy++;
         if (out_valid !== 1'b1 || out_latent !== l1) bad_lat++;
      end
      n_cmp += 2;
      if (bad_rdy != 0) begin $display("FAIL bp_in_ready cycles_high=%0d exp=0", bad_rdy); n_bad++; end
      if (bad_lat != 0) begin $display("FAIL bp_latent_hold bad_cycles=%0d exp=0 last=%h exp=%h", bad_lat, out_latent, l1); n_bad++; end
      out_ready = 1'b1;
      tick();
      n_cmp += 3;
      if (out_valid !== 1'b0) begin $display("FAIL bp_release_valid got=%0b exp=0", out_valid); n_bad++; end
      if (in_ready !== 1'b1) begin $display("FAIL bp_release_ready got=%0b exp=1", in_ready); n_bad++; end
      if (got_q.size() != 1) begin $display("FAIL bp_one_transfer got=%0d exp=1", got_q.size()); n_bad++; end
      send_frame(l2, 1'b0, 1'b0);
      wait_deliver(1'b0, v, ok);
      n_cmp++;
      if (!ok || v !== l1) begin $display("FAIL bp_first got=%h ok=%0b exp=%h", v, ok, l1); n_bad++; end
      wait_deliver(1'b0, v, ok);
      n_cmp++;
      if (!ok || v !== l2) begin $display("FAIL bp_second got=%h ok=%0b exp=%h", v, ok, l2); n_bad++; end
      $display("test_back_to_back l1=%h l2=%h", l1, l2);
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] lat, v;
      bit ok;
      send_word(HDR);
      send_word(8'h12);
      send_word(8'h34);
      rst_n = 1'b0;
      #1;
      n_cmp += 3;
      if (in_ready !== 1'b0) begin $display("FAIL mid_rst_in_ready got=%0b exp=0", in_ready); n_bad++; end
      if (out_valid !== 1'b0) begin $display("FAIL mid_rst_out_valid got=%0b exp=0", out_valid); n_bad++; end
      if (frame_cnt !== 4'h0) begin $display("FAIL mid_rst_frame_cnt got=%0d exp=0", frame_cnt); n_bad++; end
      exp_frames = 0; exp_errs = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      lat = $urandom;
      send_frame(lat, 1'b0, 1'b0);
      wait_deliver(1'b0, v, ok);
      repeat (3) tick();
      n_cmp += 3;
      if (!ok || v !== lat) begin $display("FAIL mid_rst_deliver got=%h ok=%0b exp=%h", v, ok, lat); n_bad++; end
      if (frame_cnt !== 4'h1) begin $display("FAIL mid_rst_frame_cnt_after got=%0d exp=1", frame_cnt); n_bad++; end
      if (got_q.size() != 0) begin $display("FAIL mid_rst_extra got=%0d exp=0", got_q.size()); n_bad++; end
      $display("test_reset_mid_frame latent=%h", lat);
   endtask

   task automatic test_random();
      logic [31:0] lat, v;
      bit ok, corrupt;
      for (int f = 0; f < 24; f++) begin
         lat = $urandom;
         corrupt = ($urandom_range(0, 3) == 0);
         out_ready = 1'($urandom);
         send_frame(lat, corrupt, 1'b1);
         if (!corrupt) begin
            wait_deliver(1'b1, v, ok);
            n_cmp++;
            if (!ok || v !== lat) begin $display("FAIL rand_frame%0d got=%h ok=%0b exp=%h", f, v, ok, lat); n_bad++; end
         end else begin
            out_ready = 1'b1;
            repeat (2) tick();
            n_cmp++;
            if (got_q.size() != 0) begin $display("FAIL rand_corrupt%0d delivered=%0d exp=0", f, got_q.size()); n_bad++; end
         end
         $display("rand frame %0d latent=%h corrupt=%0b", f, lat, corrupt);
      end
      tick();
      n_cmp += 2;
      if (frame_cnt !== 4'(exp_frames)) begin $display("FAIL rand_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); n_bad++; end
      if (err_cnt !== 4'(exp_errs)) begin $display("FAIL rand_err_cnt got=%0d exp=%0d", err_cnt, exp_errs); n_bad++; end
   endtask

   task automatic test_saturation();
      int e0;
      logic [31:0] lat;
      e0 = ep_cnt;
      out_ready = 1'b1;
      for (int f = 0; f < (1 << CNT_W) + 3; f++) begin
         lat = $urandom;
         send_frame(lat, 1'b1, 1'b0);
      end
      repeat (2) tick();
      n_cmp += 4;
      if (err_cnt !== 4'hF) begin $display("FAIL sat_err_cnt got=%h exp=f", err_cnt); n_bad++; end
      if (ep_cnt - e0 != (1 << CNT_W) + 3) begin $display("FAIL sat_pulses got=%0d exp=%0d", ep_cnt - e0, (1 << CNT_W) + 3); n_bad++; end
      if (out_valid !== 1'b0) begin $display("FAIL sat_out_valid got=%0b exp=0", out_valid); n_bad++; end
      if (frame_cnt !== 4'(exp_frames)) begin $display("FAIL sat_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames); n_bad++; end
      $display("test_saturation err_cnt=%h", err_cnt);
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_garbage();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
